// File: rtl/bus_rr_arbiter.sv
// Round-robin arbiter sharing one req/gnt/rvalid device port among NrHosts hosts.
// A small order FIFO routes each in-order response back to the host that issued it.
module bus_rr_arbiter #(
  parameter int NrHosts        = 3,
  parameter int DataWidth      = 32,
  parameter int AddressWidth   = 32,
  parameter int MaxOutstanding = 2
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic [NrHosts-1:0]                   host_req_i,
  output logic [NrHosts-1:0]                   host_gnt_o,
  input  logic [NrHosts*AddressWidth-1:0]      host_addr_i,
  input  logic [NrHosts-1:0]                   host_we_i,
  input  logic [NrHosts*(DataWidth/8)-1:0]     host_be_i,
  input  logic [NrHosts*DataWidth-1:0]         host_wdata_i,
  output logic [NrHosts-1:0]                   host_rvalid_o,
  output logic [NrHosts*DataWidth-1:0]         host_rdata_o,
  output logic [NrHosts-1:0]                   host_err_o,
  output logic                                 dev_req_o,
  input  logic                                 dev_gnt_i,
  output logic [AddressWidth-1:0]              dev_addr_o,
  output logic                                 dev_we_o,
  output logic [DataWidth/8-1:0]               dev_be_o,
  output logic [DataWidth-1:0]                 dev_wdata_o,
  input  logic                                 dev_rvalid_i,
  input  logic [DataWidth-1:0]                 dev_rdata_i,
  input  logic                                 dev_err_i,
  output logic [$clog2(MaxOutstanding+1)-1:0]  outstanding_o,
  output logic                                 unexpected_rsp_o
);

  localparam int IdxW = (NrHosts > 1) ? $clog2(NrHosts) : 1;
  localparam int PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam int CntW = $clog2(MaxOutstanding + 1);
  localparam int BeW  = DataWidth / 8;

  logic [IdxW-1:0] rr_ptr;
  logic [IdxW-1:0] winner;
  logic [IdxW-1:0] head;
  logic            any_req;
  logic            full;
  logic            empty;
  logic            push;
  logic            pop;
  logic            unexpected;
  logic [IdxW-1:0] order_mem [MaxOutstanding];
  logic [PtrW-1:0] wr_ptr;
  logic [PtrW-1:0] rd_ptr;
  logic [CntW-1:0] count;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    if (p == PtrW'(MaxOutstanding - 1)) return '0;
    return p + PtrW'(1);
  endfunction

  // Winner: first requester at or above the pointer, wrapping modulo NrHosts.
  always_comb begin
    winner  = rr_ptr;
    any_req = 1'b0;
    for (int i = 0; i < NrHosts; i++) begin
      automatic int cand = int'(rr_ptr) + i;
      if (cand >= NrHosts) cand = cand - NrHosts;
      if (!any_req && host_req_i[IdxW'(cand)]) begin
        winner  = IdxW'(cand);
        any_req = 1'b1;
      end
    end
  end

  assign full  = (count == CntW'(MaxOutstanding));
  assign empty = (count == '0);
  assign head  = order_mem[rd_ptr];

  // A full FIFO blocks new requests even when a response frees a slot this cycle.
  assign dev_req_o = any_req && !full && !rst_i;
  assign push      = dev_req_o && dev_gnt_i;
  assign pop       = dev_rvalid_i && !empty && !rst_i;

  assign dev_addr_o  = host_addr_i[winner*AddressWidth +: AddressWidth];
  assign dev_we_o    = host_we_i[winner];
  assign dev_be_o    = host_be_i[winner*BeW +: BeW];
  assign dev_wdata_o = host_wdata_i[winner*DataWidth +: DataWidth];

  always_comb begin
    host_gnt_o    = '0;
    host_rvalid_o = '0;
    host_err_o    = '0;
    if (push) host_gnt_o[winner] = 1'b1;
    if (pop) begin
      host_rvalid_o[head] = 1'b1;
      host_err_o[head]    = dev_err_i;
    end
  end

  assign host_rdata_o     = {NrHosts{dev_rdata_i}};
  assign outstanding_o    = count;
  assign unexpected_rsp_o = unexpected;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr     <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      unexpected <= 1'b0;
    end else begin
      if (push) begin
        rr_ptr <= (winner == IdxW'(NrHosts - 1)) ? '0 : winner + IdxW'(1);
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      if (push && !pop)      count <= count + CntW'(1);
      else if (pop && !push) count <= count - CntW'(1);
      if (dev_rvalid_i && empty) unexpected <= 1'b1;
    end
  end

  // Order storage holds only host indices; validity comes from the pointers.
  always_ff @(posedge clk_i) begin
    if (push) order_mem[wr_ptr] <= winner;
  end

endmodule
